// File: rtl/clk_gen_bank.sv
// ---------------------------------------------------------------------------
// clk_gen_bank
//   Bank of NUM_CLOCKS counter-based clock generators running off refclk.
//   Each channel has a programmable divide ratio D, high time H and phase
//   offset P. New settings wait in a shadow register and are applied only at
//   a period boundary, so an output never shows a runt pulse. A lock flag
//   reports when the bank has been free of config activity for LOCK_CYCLES.
//
// Ports
//   refclk    : reference clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   ch_en     : per-channel run enable
//   resync    : one-cycle pulse, realigns every channel to its phase offset
//   cfg_we    : config write strobe
//   cfg_sel   : channel targeted by the write
//   cfg_div   : divide ratio D
//   cfg_high  : high cycles H per period
//   cfg_phase : phase offset P in refclk cycles
//   outclk    : generated clocks (registered)
//   tick      : one-cycle pulse at the start of each outclk period
//   locked    : bank has been quiet for LOCK_CYCLES edges
//   cfg_err   : one-cycle pulse when a write is rejected
// ---------------------------------------------------------------------------
module clk_gen_bank #(
    parameter int NUM_CLOCKS   = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int DEFAULT_DIV  = 2,
    parameter int DEFAULT_HIGH = 1,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic                                                 refclk,
    input  logic                                                 rst,
    input  logic [NUM_CLOCKS-1:0]                                ch_en,
    input  logic                                                 resync,
    input  logic                                                 cfg_we,
    input  logic [((NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1)-1:0] cfg_sel,
    input  logic [CNT_WIDTH-1:0]                                 cfg_div,
    input  logic [CNT_WIDTH-1:0]                                 cfg_high,
    input  logic [CNT_WIDTH-1:0]                                 cfg_phase,
    output logic [NUM_CLOCKS-1:0]                                outclk,
    output logic [NUM_CLOCKS-1:0]                                tick,
    output logic                                                 locked,
    output logic                                                 cfg_err
);

    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] DEF_DIV  = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] DEF_HIGH = CNT_WIDTH'(DEFAULT_HIGH);
    localparam logic [LOCK_W-1:0]    LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    // Active and shadow configuration, plus the per-channel counter.
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_actDiv;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_actHigh;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_actPhase;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_shDiv;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_shHigh;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_shPhase;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] r_cnt;
    logic [NUM_CLOCKS-1:0]                r_pending;
    logic [NUM_CLOCKS-1:0]                r_outclk;
    logic [NUM_CLOCKS-1:0]                r_tick;
    logic [LOCK_W-1:0]                    r_lockCnt;
    logic                                 r_locked;
    logic                                 r_cfgErr;

    logic [31:0]                          w_selWide;
    logic                                 w_cfgLegal;
    logic                                 w_cfgAccept;
    logic                                 w_lockClear;
    logic [NUM_CLOCKS-1:0]                w_wr;
    logic [NUM_CLOCKS-1:0]                w_anchor;
    logic [NUM_CLOCKS-1:0]                w_wrap;
    logic [NUM_CLOCKS-1:0]                w_apply;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] w_effDiv;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] w_effHigh;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] w_effPhase;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] w_preload;
    logic [NUM_CLOCKS-1:0][CNT_WIDTH-1:0] w_cntNext;
    logic [NUM_CLOCKS-1:0]                w_outNext;
    logic [NUM_CLOCKS-1:0]                w_tickNext;

    // Write qualification. H < D and P < D are the overflow-safe forms of
    // H <= D-1 and P <= D-1.
    always_comb begin
        w_selWide   = 32'(cfg_sel);
        w_cfgLegal  = (cfg_div >= TWO) && (cfg_high != '0) &&
                      (cfg_high < cfg_div) && (cfg_phase < cfg_div);
        w_cfgAccept = cfg_we && w_cfgLegal && (w_selWide < 32'(NUM_CLOCKS));
        w_lockClear = w_cfgAccept || resync || (|r_pending);
    end

    // Per-channel next state. A channel is "anchored" (held at its preload
    // with outputs low) while disabled or during resync. The config used for
    // the next cycle is the shadow when it is being applied on this edge, so
    // the preload and the high-time compare already see the new values.
    always_comb begin
        w_wr       = '0;
        w_anchor   = '0;
        w_wrap     = '0;
        w_apply    = '0;
        w_effDiv   = r_actDiv;
        w_effHigh  = r_actHigh;
        w_effPhase = r_actPhase;
        w_preload  = '0;
        w_cntNext  = '0;
        w_outNext  = '0;
        w_tickNext = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            w_wr[i]     = w_cfgAccept && (w_selWide == 32'(i));
            w_anchor[i] = resync || !ch_en[i];
            w_wrap[i]   = (r_cnt[i] == r_actDiv[i] - ONE);
            w_apply[i]  = r_pending[i] && (w_anchor[i] || w_wrap[i]);
            if (w_apply[i]) begin
                w_effDiv[i]   = r_shDiv[i];
                w_effHigh[i]  = r_shHigh[i];
                w_effPhase[i] = r_shPhase[i];
            end
            // Preload is one step before P so the first counting edge lands on P.
            w_preload[i] = (w_effPhase[i] == '0) ? (w_effDiv[i] - ONE)
                                                 : (w_effPhase[i] - ONE);
            if (w_anchor[i]) begin
                w_cntNext[i] = w_preload[i];
            end else if (w_wrap[i]) begin
                w_cntNext[i] = '0;
            end else begin
                w_cntNext[i] = r_cnt[i] + ONE;
            end
            w_outNext[i]  = !w_anchor[i] && (w_cntNext[i] < w_effHigh[i]);
            w_tickNext[i] = !w_anchor[i] && (w_cntNext[i] == '0);
        end
    end

    // Channel registers. A write on the same edge as an apply leaves the new
    // value pending, so it never joins the boundary that is happening now.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                r_actDiv[i]   <= DEF_DIV;
                r_actHigh[i]  <= DEF_HIGH;
                r_actPhase[i] <= '0;
                r_shDiv[i]    <= DEF_DIV;
                r_shHigh[i]   <= DEF_HIGH;
                r_shPhase[i]  <= '0;
                r_cnt[i]      <= DEF_DIV - ONE;
            end
            r_pending <= '0;
            r_outclk  <= '0;
            r_tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                r_cnt[i] <= w_cntNext[i];
                if (w_apply[i]) begin
                    r_actDiv[i]   <= r_shDiv[i];
                    r_actHigh[i]  <= r_shHigh[i];
                    r_actPhase[i] <= r_shPhase[i];
                end
                if (w_wr[i]) begin
                    r_shDiv[i]    <= cfg_div;
                    r_shHigh[i]   <= cfg_high;
                    r_shPhase[i]  <= cfg_phase;
                    r_pending[i]  <= 1'b1;
                end else if (w_apply[i]) begin
                    r_pending[i]  <= 1'b0;
                end
            end
            r_outclk <= w_outNext;
            r_tick   <= w_tickNext;
        end
    end

    // Lock tracking and write-reject pulse. Once the count reaches its last
    // value it stays there and locked is held until the next disturbance.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lockCnt <= '0;
            r_locked  <= 1'b0;
            r_cfgErr  <= 1'b0;
        end else begin
            r_cfgErr <= cfg_we && !w_cfgAccept;
            if (w_lockClear) begin
                r_lockCnt <= '0;
                r_locked  <= 1'b0;
            end else if (r_lockCnt == LOCK_LAST) begin
                r_locked  <= 1'b1;
            end else begin
                r_lockCnt <= r_lockCnt + 1'b1;
            end
        end
    end

    assign outclk  = r_outclk;
    assign tick    = r_tick;
    assign locked  = r_locked;
    assign cfg_err = r_cfgErr;

endmodule

// File: tb/tb_clk_gen_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_gen_bank
//   Self-checking bench for clk_gen_bank. A behavioural model tracks each
//   channel as a position within its period, (origin + edges) mod D, and
//   lock as a run length of quiet edges. A second, 3-channel instance covers
//   the out-of-range channel select that a 2-bit select cannot reach on the
//   4-channel instance.
// ---------------------------------------------------------------------------
module tb_clk_gen_bank;

    localparam int NC       = 4;
    localparam int DEF_D    = 2;
    localparam int DEF_H    = 1;
    localparam int LOCK_CYC = 16;

    logic        refclk;
    logic        rst;
    logic [3:0]  ch_en;
    logic        resync;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic [15:0] cfg_phase;
    logic [3:0]  outclk;
    logic [3:0]  tick;
    logic        locked;
    logic        cfg_err;

    logic [2:0]  outclk3;
    logic [2:0]  tick3;
    logic        locked3;
    logic        cfgErr3;

    int total = 0;
    int bad   = 0;

    // Model state
    int   mDiv[NC], mHigh[NC], mPh[NC];
    int   sDiv[NC], sHigh[NC], sPh[NC];
    bit   mPend[NC];
    int   mOrg[NC], mN[NC];
    logic [3:0] expOut, expTick;
    logic expLocked, expErr;
    int   quietRun;

    clk_gen_bank #(
        .NUM_CLOCKS(4), .CNT_WIDTH(16), .DEFAULT_DIV(DEF_D),
        .DEFAULT_HIGH(DEF_H), .LOCK_CYCLES(LOCK_CYC)
    ) dut (
        .refclk(refclk), .rst(rst), .ch_en(ch_en), .resync(resync),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
        .cfg_high(cfg_high), .cfg_phase(cfg_phase), .outclk(outclk),
        .tick(tick), .locked(locked), .cfg_err(cfg_err)
    );

    clk_gen_bank #(
        .NUM_CLOCKS(3), .CNT_WIDTH(16), .DEFAULT_DIV(DEF_D),
        .DEFAULT_HIGH(DEF_H), .LOCK_CYCLES(LOCK_CYC)
    ) dut3 (
        .refclk(refclk), .rst(rst), .ch_en(3'b111), .resync(resync),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
        .cfg_high(cfg_high), .cfg_phase(cfg_phase), .outclk(outclk3),
        .tick(tick3), .locked(locked3), .cfg_err(cfgErr3)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Reference model: one rising edge, using the inputs seen at that edge.
    task automatic modelEdge();
        bit acc;
        bit anyPend;
        int pos;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                mDiv[c] = DEF_D; mHigh[c] = DEF_H; mPh[c] = 0;
                sDiv[c] = DEF_D; sHigh[c] = DEF_H; sPh[c] = 0;
                mPend[c] = 0;
                mOrg[c] = mPh[c] + mDiv[c] - 1;
                mN[c] = 0;
            end
            expOut = '0; expTick = '0; expLocked = 0; expErr = 0;
            quietRun = 0;
        end else begin
            acc = cfg_we && (int'(cfg_sel) < NC) && (cfg_div >= 2) &&
                  (cfg_high >= 1) && (cfg_high < cfg_div) && (cfg_phase < cfg_div);
            expErr = cfg_we && !acc;
            anyPend = 0;
            for (int c = 0; c < NC; c++) anyPend |= mPend[c];
            for (int c = 0; c < NC; c++) begin
                if (resync || !ch_en[c]) begin
                    if (mPend[c]) begin
                        mDiv[c] = sDiv[c]; mHigh[c] = sHigh[c]; mPh[c] = sPh[c];
                        mPend[c] = 0;
                    end
                    mOrg[c] = mPh[c] + mDiv[c] - 1;
                    mN[c] = 0;
                    expOut[c] = 0;
                    expTick[c] = 0;
                end else begin
                    pos = (mOrg[c] + mN[c]) % mDiv[c];
                    if (pos == mDiv[c] - 1 && mPend[c]) begin
                        mDiv[c] = sDiv[c]; mHigh[c] = sHigh[c]; mPh[c] = sPh[c];
                        mPend[c] = 0;
                        mOrg[c] = 0;
                        mN[c] = 0;
                    end else begin
                        mN[c]++;
                    end
                    pos = (mOrg[c] + mN[c]) % mDiv[c];
                    expOut[c]  = (pos < mHigh[c]);
                    expTick[c] = (pos == 0);
                end
                if (acc && int'(cfg_sel) == c) begin
                    sDiv[c] = int'(cfg_div); sHigh[c] = int'(cfg_high);
                    sPh[c] = int'(cfg_phase);
                    mPend[c] = 1;
                end
            end
            if (acc || resync || anyPend) begin
                quietRun = 0;
                expLocked = 0;
            end else begin
                quietRun++;
                expLocked = (quietRun >= LOCK_CYC);
            end
        end
    endtask

    // Advance one edge: model follows the DUT, outputs sampled 1 ns later.
    task automatic stepCycle();
        @(posedge refclk);
        modelEdge();
        #1;
    endtask

    task automatic applyWrite(input int sel, input int d, input int h, input int p);
        cfg_we = 1; cfg_sel = 2'(sel);
        cfg_div = 16'(d); cfg_high = 16'(h); cfg_phase = 16'(p);
        stepCycle();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        rst = 1; ch_en = 4'h0; resync = 0; cfg_we = 0; cfg_sel = 0;
        cfg_div = 0; cfg_high = 0; cfg_phase = 0;
        repeat (3) stepCycle();
        total++;
        if ({outclk, tick, locked, cfg_err} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL reset_state got=%b exp=%b", {outclk, tick, locked, cfg_err}, 10'b0);
        end
        rst = 0;
    endtask

    task automatic test_defaults();
        ch_en = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL defaults_vec edge=%0d got=%b exp=%b", k,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
            total++;
            if (outclk !== ((k % 2 == 1) ? 4'hF : 4'h0)) begin
                bad++;
                $display("[TB] FAIL defaults_toggle edge=%0d got=%h exp=%h", k, outclk,
                         (k % 2 == 1) ? 4'hF : 4'h0);
            end
            if (k == 15 || k == 16) begin
                total++;
                if (locked !== (k == 16)) begin
                    bad++;
                    $display("[TB] FAIL defaults_lock edge=%0d got=%b exp=%b", k, locked, (k == 16));
                end
            end
        end
    endtask

    task automatic test_reconfig();
        bit pat[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        for (int k = 0; k < 4 && expOut[1] !== 1'b1; k++) stepCycle();
        applyWrite(1, 5, 2, 0);
        total++;
        if (locked !== 1'b0 || outclk[1] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reconfig_write_edge locked=%b outclk1=%b exp locked=0 outclk1=0", locked, outclk[1]);
        end
        for (int k = 1; k <= 17; k++) begin
            stepCycle();
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL reconfig_vec edge=%0d got=%b exp=%b", k,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
            if (k <= 10) begin
                total++;
                if (outclk[1] !== pat[k-1]) begin
                    bad++;
                    $display("[TB] FAIL reconfig_pattern edge=%0d got=%b exp=%b", k, outclk[1], pat[k-1]);
                end
            end
            if (k == 16 || k == 17) begin
                total++;
                if (locked !== (k == 17)) begin
                    bad++;
                    $display("[TB] FAIL reconfig_relock edge=%0d got=%b exp=%b", k, locked, (k == 17));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        applyWrite(1, 7, 3, 0);
        applyWrite(1, 3, 1, 0);
        for (int k = 0; k < 20; k++) begin
            stepCycle();
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL back_to_back_vec edge=%0d got=%b exp=%b", k,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
        end
    endtask

    task automatic test_resync_phase();
        int waitCnt;
        bit e0, e2;
        applyWrite(0, 4, 2, 0);
        applyWrite(2, 4, 2, 2);
        waitCnt = 0;
        while ((mPend[0] || mPend[2]) && waitCnt < 20) begin
            stepCycle();
            waitCnt++;
        end
        total++;
        if (mPend[0] || mPend[2]) begin
            bad++;
            $display("[TB] FAIL resync_apply_timeout pend0=%0d pend2=%0d exp=0", mPend[0], mPend[2]);
        end
        resync = 1;
        stepCycle();
        resync = 0;
        total++;
        if ({outclk, tick} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL resync_edge got=%b exp=%b", {outclk, tick}, 8'h00);
        end
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            e0 = ((k % 4) < 2);
            e2 = (((k + 2) % 4) < 2);
            total++;
            if ({outclk[0], outclk[2], tick[0], tick[2]} !== {e0, e2, (k % 4 == 0), (k % 4 == 2)}) begin
                bad++;
                $display("[TB] FAIL resync_offset k=%0d got=%b exp=%b", k,
                         {outclk[0], outclk[2], tick[0], tick[2]}, {e0, e2, (k % 4 == 0), (k % 4 == 2)});
            end
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL resync_vec k=%0d got=%b exp=%b", k,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
        end
    endtask

    task automatic test_reject();
        int cases[4][3] = '{'{1, 1, 0}, '{5, 0, 0}, '{5, 5, 0}, '{5, 2, 5}};
        for (int k = 0; k < 60 && !expLocked; k++) stepCycle();
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reject_prelock got=%b exp=1", locked);
        end
        for (int c = 0; c < 4; c++) begin
            applyWrite(1, cases[c][0], cases[c][1], cases[c][2]);
            total++;
            if ({cfg_err, locked} !== 2'b11) begin
                bad++;
                $display("[TB] FAIL reject_pulse case=%0d err,locked got=%b exp=11", c, {cfg_err, locked});
            end
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL reject_vec case=%0d got=%b exp=%b", c,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
            stepCycle();
            total++;
            if ({cfg_err, locked} !== 2'b01) begin
                bad++;
                $display("[TB] FAIL reject_single case=%0d err,locked got=%b exp=01", c, {cfg_err, locked});
            end
        end
    endtask

    task automatic test_sel_range();
        applyWrite(3, 5, 2, 0);
        total++;
        if ({cfgErr3, cfg_err} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL sel_range_reject err3,err got=%b exp=10", {cfgErr3, cfg_err});
        end
        applyWrite(2, 5, 2, 0);
        total++;
        if ({cfgErr3, cfg_err} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL sel_range_accept err3,err got=%b exp=00", {cfgErr3, cfg_err});
        end
    endtask

    task automatic test_disabled();
        bit pat[6] = '{0, 0, 1, 0, 0, 1};
        ch_en = 4'h7;
        repeat (2) stepCycle();
        applyWrite(3, 3, 1, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (outclk[3] !== 1'b0 || tick[3] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL disabled_quiet k=%0d got=%b exp=00", k, {outclk[3], tick[3]});
            end
            stepCycle();
        end
        ch_en = 4'hF;
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            total++;
            if ({outclk[3], tick[3]} !== {pat[k], pat[k]}) begin
                bad++;
                $display("[TB] FAIL disabled_resume k=%0d got=%b exp=%b", k, {outclk[3], tick[3]}, {pat[k], pat[k]});
            end
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL disabled_vec k=%0d got=%b exp=%b", k,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
        end
    endtask

    task automatic test_reset_mid();
        applyWrite(2, 6, 3, 0);
        rst = 1;
        stepCycle();
        rst = 0;
        total++;
        if ({outclk, tick, locked} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_state got=%b exp=%b", {outclk, tick, locked}, 9'b0);
        end
        for (int k = 1; k <= 18; k++) begin
            stepCycle();
            total++;
            if (outclk[2] !== (k % 2 == 1)) begin
                bad++;
                $display("[TB] FAIL reset_mid_default edge=%0d got=%b exp=%b", k, outclk[2], (k % 2 == 1));
            end
            total++;
            if (locked !== (k >= 16)) begin
                bad++;
                $display("[TB] FAIL reset_mid_lock edge=%0d got=%b exp=%b", k, locked, (k >= 16));
            end
        end
    endtask

    task automatic test_random();
        int d;
        for (int k = 0; k < 500; k++) begin
            cfg_we = ($urandom_range(0, 5) == 0);
            d = $urandom_range(0, 9);
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_div = 16'(d);
            cfg_high = 16'($urandom_range(0, d));
            cfg_phase = 16'($urandom_range(0, d));
            resync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom_range(0, 15));
            stepCycle();
            total++;
            if ({outclk, tick, locked, cfg_err} !== {expOut, expTick, expLocked, expErr}) begin
                bad++;
                $display("[TB] FAIL random_vec k=%0d got=%b exp=%b", k,
                         {outclk, tick, locked, cfg_err}, {expOut, expTick, expLocked, expErr});
            end
        end
        cfg_we = 0;
        resync = 0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reconfig();
        test_back_to_back();
        test_resync_phase();
        test_reject();
        test_sel_range();
        test_disabled();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_gen_bank.md
Name: clk_gen_bank

Overview:
- Parametrised bank of NUM_CLOCKS programmable counter-based clock generators, all driven from one reference clock.
- Each channel has a runtime-programmable divide ratio, high time (duty cycle) and phase offset.
- Config changes are glitch-free: they take effect only at a period boundary.
- A `locked` flag reports when all channels have settled. The bank sits beside the PLL and produces slow, low-frequency derived clocks and clock-enables (audio, VGA and game-tick rates) without regenerating the PLL.

Parameters:
- NUM_CLOCKS, 4, number of output channels (1..16)
- CNT_WIDTH, 16, width of divide, high and phase fields and of each channel counter
- DEFAULT_DIV, 2, divide ratio loaded at reset (>=2)
- DEFAULT_HIGH, 1, high time loaded at reset (1..DEFAULT_DIV-1)
- LOCK_CYCLES, 16, settle cycles before `locked` asserts (>=1)

Ports:
- refclk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ch_en  in  NUM_CLOCKS  per-channel run enable
- resync  in  1  one-cycle pulse; realigns all channels to their phase offsets
- cfg_we  in  1  config write strobe
- cfg_sel  in  max(1,$clog2(NUM_CLOCKS))  target channel
- cfg_div  in  CNT_WIDTH  divide ratio D
- cfg_high  in  CNT_WIDTH  high cycles H per period
- cfg_phase  in  CNT_WIDTH  phase offset P in refclk cycles
- outclk  out  NUM_CLOCKS  generated clocks, registered
- tick  out  NUM_CLOCKS  one-cycle pulse coincident with each outclk rising period start
- locked  out  1  all channels stable for LOCK_CYCLES
- cfg_err  out  1  one-cycle pulse, write rejected

Behaviour:

Reset and per-channel state:
- Reset applies on any edge with rst=1. Every channel is set to active = shadow = {DEFAULT_DIV, DEFAULT_HIGH, 0}, pending=0, cnt=preload.
- Reset outputs: outclk=0, tick=0, locked=0, cfg_err=0, lock_cnt=0.
- preload = (P==0) ? D-1 : P-1.

Counting:
- Enabled channel, each edge: cnt <= (cnt==D-1) ? 0 : cnt+1.
- outclk and tick are registered on the same edge: outclk = (cnt_new < H), tick = (cnt_new == 0).
- The first enabled edge after reset, resync or enable therefore gives cnt=P.
- Disabled channel: cnt held at preload, outclk=0, tick=0. Re-enabling resumes from preload, with no runt pulse.

Config writes:
- A write is accepted iff cfg_sel < NUM_CLOCKS, D >= 2, 1 <= H <= D-1 and P <= D-1.
- Accepted write: the shadow register of the selected channel is loaded and pending is set. A second write while pending overwrites the shadow (last write wins).
- Rejected write: no state change; cfg_err=1 on the next edge only; `locked` is unaffected.

Config apply:
- Pending shadow is copied to active on the first edge strictly after the write at which the channel wraps (cnt==D_old-1, enabled). cnt goes to 0 with the new D/H, so the old period always completes.
- If the channel is disabled, apply happens on the next edge and cnt is reloaded with the new preload.

Resync:
- resync=1: all channels apply any pending shadow, load cnt=preload and drive outclk=0, tick=0 on that edge. Next enabled edge gives cnt=P, so relative phase between channels equals the difference in P.
- resync together with cfg_we: the write lands in the shadow and is applied at the next wrap; it does not join this resync.

Lock:
- If on an edge any of the following holds, then lock_cnt <= 0 and locked <= 0:
  - an accepted write,
  - resync,
  - any pending=1.
- Otherwise, if lock_cnt == LOCK_CYCLES-1, then locked <= 1 and is held.
- Otherwise lock_cnt increments.
- locked therefore rises on the LOCK_CYCLES-th quiet edge. ch_en changes do not affect locked.

Widths and limits:
- Comparisons are unsigned, CNT_WIDTH bits. D up to 2^CNT_WIDTH-1.
- outclk period = D, high time = H, exactly, for all legal values.

Reset mid-operation:
- All pending writes are discarded and the defaults from reset are restored.

Test Plan:
1. Reset, then ch_en=4'hF with defaults: all outclk toggle 1,0,1,0 in phase starting on the first edge after rst deasserts; tick on every high cycle; locked=1 on the 16th edge.
2. Write ch1 D=5 H=2 P=0 mid-period: outclk[1] finishes the old 2-cycle period, then repeats 1,1,0,0,0; locked drops on the edge after the write and re-rises 16 edges after the apply edge.
3. ch0 and ch2 D=4 H=2, P=0 and P=2 respectively, then resync: outclk[2] rises 2 cycles after outclk[0] on every period; tick[0] and tick[2] are also offset by 2.
4. Rejected writes, one at a time: D=1; H=0; H=D; P=D; cfg_sel=NUM_CLOCKS. Each gives a single cfg_err pulse; outputs unchanged; locked stays 1.
5. Set ch_en[3]=0, write D=3 H=1 P=1: outclk[3] stays 0 and apply happens the next edge. Then ch_en[3]=1: first cycle cnt=1 so outclk=0, then 0, then pulse 1 at cnt=0, period 3.
6. Accepted write pending on ch2, then rst pulse for 1 cycle: pending is discarded, ch2 returns to D=2 H=1, locked=0 and re-rises after 16 edges.
